// File: rtl/nn_pkg.sv
// Shared types and fixed-point helpers for the dense layer engine.
package nn_pkg;

  localparam int unsigned XW = 64;

  typedef enum logic [1:0] {ACT_ID, ACT_RELU, ACT_HSIG} act_t;

  typedef enum logic [1:0] {ST_LOAD, ST_MAC, ST_DRAIN, ST_OUT} state_t;

  // Clip a wide signed value into the signed dw-bit range.
  function automatic logic signed [XW-1:0] sat_dw(input logic signed [XW-1:0] v,
                                                  input int unsigned dw);
    logic signed [XW-1:0] hi;
    logic signed [XW-1:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi)      sat_dw = hi;
    else if (v < lo) sat_dw = lo;
    else             sat_dw = v;
  endfunction

  // Activation on a value already limited to the data range.
  function automatic logic signed [XW-1:0] act_apply(input logic signed [XW-1:0] v,
                                                     input act_t act,
                                                     input int unsigned frac);
    logic signed [XW-1:0] t;
    logic signed [XW-1:0] one;
    t   = (v >>> 2) + (64'sd1 <<< (frac - 1));
    one = 64'sd1 <<< frac;
    case (act)
      ACT_RELU: act_apply = (v < 64'sd0) ? 64'sd0 : v;
      ACT_HSIG: begin
        if (t < 64'sd0)     act_apply = 64'sd0;
        else if (t > one)   act_apply = one;
        else                act_apply = t;
      end
      default:  act_apply = v;
    endcase
  endfunction

endpackage

// File: rtl/nn_mac.sv
// Shared multiply-accumulate datapath: weight products, scaled bias, rescale and saturation.
module nn_mac
  import nn_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned ACC_W = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 add,
  input  logic                 bias,
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] w,
  output logic signed [DW-1:0] res_c,
  output logic                 sat_c
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] sum;
  logic signed [XW-1:0]    r_wide;
  logic signed [XW-1:0]    r_sat;

  // Result reflects the in-flight addend so the final bias is included the cycle it lands.
  always_comb begin
    prod   = (2*DW)'(x) * (2*DW)'(w);
    addend = '0;
    if (add) addend = bias ? (ACC_W'(w) <<< FRAC) : ACC_W'(prod);
    sum    = acc + addend;
    r_wide = XW'(sum >>> FRAC);
    r_sat  = sat_dw(r_wide, DW);
    sat_c  = (r_sat != r_wide);
    res_c  = DW'(r_sat);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (add)   acc <= sum;
  end

endmodule

// File: rtl/dense_layer_engine.sv
// Fully connected layer: buffers one input vector, then evaluates each neuron serially
// against weights/bias streamed from an external synchronous memory.
module dense_layer_engine
  import nn_pkg::*;
#(
  parameter int unsigned N_IN   = 16,
  parameter int unsigned N_OUT  = 10,
  parameter int unsigned DW     = 16,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned ACT    = 1,
  parameter int unsigned MEM_AW = $clog2(N_OUT * (N_IN + 1)),
  parameter int unsigned OIW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_en,
  input  logic [DW-1:0]     mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [OIW-1:0]    out_idx,
  output logic              out_last,
  output logic              out_sat,
  output logic              busy
);

  localparam int unsigned CW = $clog2(N_IN + 1);
  localparam int unsigned BW = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [1:0] S_LOAD  = ST_LOAD;
  localparam logic [1:0] S_MAC   = ST_MAC;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_OUT   = ST_OUT;

  localparam act_t ACT_SEL = act_t'(2'(ACT));

  logic [1:0]           state;
  logic [1:0]           state_n;
  logic [CW-1:0]        cnt;
  logic [OIW-1:0]       j;
  logic [MEM_AW-1:0]    base;
  logic                 ret_vld;
  logic [CW-1:0]        ret_idx;
  logic signed [DW-1:0] buffer [N_IN];
  logic signed [DW-1:0] x_sel;
  logic signed [DW-1:0] res_c;
  logic                 sat_c;
  logic                 in_hs_c;
  logic                 last_in_c;
  logic                 last_j_c;
  logic                 bias_c;
  logic                 clr_c;

  // Next-state and per-cycle control decode.
  always_comb begin
    state_n   = state;
    in_hs_c   = in_valid && in_ready;
    last_in_c = (cnt == CW'(N_IN - 1));
    last_j_c  = (j == OIW'(N_OUT - 1));
    case (state)
      S_LOAD:  if (in_hs_c && last_in_c) state_n = S_MAC;
      S_MAC:   if (cnt == CW'(N_IN)) state_n = S_DRAIN;
      S_DRAIN: state_n = S_OUT;
      S_OUT:   if (out_ready) state_n = last_j_c ? S_LOAD : S_MAC;
      default: state_n = S_LOAD;
    endcase
    clr_c = (state_n == S_MAC) && (state != S_MAC);
  end

  // Returned word N_IN of each neuron is its bias, which pairs with no input element.
  always_comb begin
    bias_c = (ret_idx == CW'(N_IN));
    x_sel  = '0;
    if (!bias_c) x_sel = buffer[BW'(ret_idx)];
  end

  always_ff @(posedge clk) begin
    if (!rst && state == S_LOAD && in_hs_c) buffer[BW'(cnt)] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOAD;
      cnt       <= '0;
      j         <= '0;
      base      <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      ret_vld   <= 1'b0;
      ret_idx   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      state    <= state_n;
      in_ready <= (state_n == S_LOAD);
      busy     <= (state_n != S_LOAD);
      mem_en   <= (state_n == S_MAC);
      ret_vld  <= mem_en;
      ret_idx  <= cnt;
      case (state)
        S_LOAD: begin
          if (in_hs_c) begin
            cnt <= last_in_c ? '0 : cnt + CW'(1);
            if (last_in_c) mem_addr <= base;
          end
        end
        S_MAC: begin
          if (cnt == CW'(N_IN)) begin
            cnt <= '0;
          end else begin
            cnt      <= cnt + CW'(1);
            mem_addr <= mem_addr + MEM_AW'(1);
          end
        end
        S_DRAIN: begin
          out_valid <= 1'b1;
          out_data  <= DW'(act_apply(XW'(res_c), ACT_SEL, FRAC));
          out_sat   <= sat_c;
          out_idx   <= j;
          out_last  <= last_j_c;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_j_c) begin
              j    <= '0;
              base <= '0;
            end else begin
              j        <= j + OIW'(1);
              base     <= base + MEM_AW'(N_IN + 1);
              mem_addr <= base + MEM_AW'(N_IN + 1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  nn_mac #(
    .DW    (DW),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_c),
    .add   (ret_vld),
    .bias  (bias_c),
    .x     (x_sel),
    .w     (mem_data),
    .res_c (res_c),
    .sat_c (sat_c)
  );

endmodule

// File: tb/tb_dense_layer_engine.sv
// Directed bench: three engines (identity, ReLU, hard sigmoid) run the same frames in lockstep.
module tb_dense_layer_engine;

  localparam int unsigned N_IN   = 4;
  localparam int unsigned N_OUT  = 2;
  localparam int unsigned DW     = 16;
  localparam int unsigned FRAC   = 8;
  localparam int unsigned ACC_W  = 40;
  localparam int unsigned MEM_AW = 4;
  localparam int unsigned NA     = 3;
  localparam int unsigned DEPTH  = N_OUT * (N_IN + 1);
  localparam int          WAIT_MAX = 100;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          in_valid  = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          out_ready = 1'b1;

  logic              in_ready  [NA];
  logic              mem_en    [NA];
  logic [MEM_AW-1:0] mem_addr  [NA];
  logic              out_valid [NA];
  logic [DW-1:0]     out_data  [NA];
  logic              out_idx   [NA];
  logic              out_last  [NA];
  logic              out_sat   [NA];
  logic              busy      [NA];

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] xv  [N_IN];
  logic [DW-1:0] ev  [NA][N_OUT];
  logic          es  [N_OUT];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NA; g++) begin : g_act
    logic [DW-1:0] rdata;
    always @(posedge clk) if (mem_en[g]) rdata <= mem[mem_addr[g]];

    dense_layer_engine #(
      .N_IN  (N_IN),
      .N_OUT (N_OUT),
      .DW    (DW),
      .FRAC  (FRAC),
      .ACC_W (ACC_W),
      .ACT   (g)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .in_data   (in_data),
      .mem_addr  (mem_addr[g]),
      .mem_en    (mem_en[g]),
      .mem_data  (rdata),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_data  (out_data[g]),
      .out_idx   (out_idx[g]),
      .out_last  (out_last[g]),
      .out_sat   (out_sat[g]),
      .busy      (busy[g])
    );
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_mem(input logic [DW-1:0] w, input logic [DW-1:0] b);
    for (int n = 0; n < N_OUT; n++) begin
      for (int i = 0; i < N_IN; i++) mem[n*(N_IN+1)+i] = w;
      mem[n*(N_IN+1)+N_IN] = b;
    end
  endtask

  task automatic set_x(input logic [DW-1:0] v);
    for (int i = 0; i < N_IN; i++) xv[i] = v;
  endtask

  task automatic set_exp(input logic [DW-1:0] e_id, input logic [DW-1:0] e_relu,
                         input logic [DW-1:0] e_hsig, input logic sat);
    for (int n = 0; n < N_OUT; n++) begin
      ev[0][n] = e_id;
      ev[1][n] = e_relu;
      ev[2][n] = e_hsig;
      es[n]    = sat;
    end
  endtask

  task automatic chk_reset(input string nm, input logic exp_rdy);
    for (int g = 0; g < NA; g++) begin
      chk_eq($sformatf("%s_in_ready_a%0d", nm, g), 32'(in_ready[g]), 32'(exp_rdy));
      chk_eq($sformatf("%s_out_valid_a%0d", nm, g), 32'(out_valid[g]), 32'd0);
      chk_eq($sformatf("%s_out_data_a%0d", nm, g), 32'(out_data[g]), 32'd0);
      chk_eq($sformatf("%s_out_flags_a%0d", nm, g),
             32'({out_idx[g], out_last[g], out_sat[g]}), 32'd0);
      chk_eq($sformatf("%s_mem_a%0d", nm, g), 32'({mem_en[g], mem_addr[g]}), 32'd0);
      chk_eq($sformatf("%s_busy_a%0d", nm, g), 32'(busy[g]), 32'd0);
    end
  endtask

  task automatic feed(input string nm, output int t0);
    int wd;
    t0 = 0;
    for (int i = 0; i < N_IN; i++) begin
      in_valid = 1'b1;
      in_data  = xv[i];
      wd = 0;
      while (!in_ready[0] && wd < WAIT_MAX) begin
        @(negedge clk);
        wd++;
      end
      chk_eq($sformatf("%s_in_ready_%0d", nm, i), 32'(in_ready[0]), 32'd1);
      if (i == 0) t0 = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic take(input string nm, input int n, input int stall, output int t);
    int            wd;
    logic          ok;
    logic [DW-1:0] snap [NA];
    out_ready = (stall == 0);
    wd = 0;
    while (!out_valid[0] && wd < WAIT_MAX) begin
      @(negedge clk);
      wd++;
    end
    chk_eq($sformatf("%s_out_valid_n%0d", nm, n), 32'(out_valid[0]), 32'd1);
    if (stall != 0) begin
      ok = 1'b1;
      for (int g = 0; g < NA; g++) snap[g] = out_data[g];
      for (int s = 0; s < 5; s++) begin
        for (int g = 0; g < NA; g++)
          if (out_data[g] !== snap[g] || out_valid[g] !== 1'b1 || mem_en[g] !== 1'b0 ||
              out_idx[g] !== 1'(n))
            ok = 1'b0;
        @(negedge clk);
      end
      chk_eq($sformatf("%s_stall_hold_n%0d", nm, n), 32'(ok), 32'd1);
      out_ready = 1'b1;
    end
    for (int g = 0; g < NA; g++) begin
      chk_eq($sformatf("%s_data_a%0d_n%0d", nm, g, n), 32'(out_data[g]), 32'(ev[g][n]));
      chk_eq($sformatf("%s_idx_a%0d_n%0d", nm, g, n), 32'(out_idx[g]), 32'(n));
      chk_eq($sformatf("%s_last_a%0d_n%0d", nm, g, n), 32'(out_last[g]), 32'(n == N_OUT - 1));
      chk_eq($sformatf("%s_sat_a%0d_n%0d", nm, g, n), 32'(out_sat[g]), 32'(es[n]));
    end
    t = cyc;
    @(negedge clk);
  endtask

  task automatic run_frame(input string nm, input int stall, input int exp_len);
    int t0;
    int t1;
    feed(nm, t0);
    t1 = t0;
    for (int n = 0; n < N_OUT; n++) take(nm, n, stall, t1);
    chk_eq({nm, "_frame_cycles"}, 32'(t1 - t0 + 1), 32'(exp_len));
    chk_eq({nm, "_in_ready_after"}, 32'(in_ready[0]), 32'd1);
    chk_eq({nm, "_busy_after"}, 32'(busy[0]), 32'd0);
  endtask

  initial begin
    int t0;
    int t1;
    repeat (2) @(negedge clk);
    chk_reset("por", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_reset("por_rel", 1'b1);

    // 4 x (1.0*1.0) + 0.5 = 4.5
    set_x(16'h0100); set_mem(16'h0100, 16'h0080);
    set_exp(16'h0480, 16'h0480, 16'h0100, 1'b0);
    run_frame("v1", 0, 18);

    // 4 x (1.0*-1.0) = -4.0
    set_x(16'h0100); set_mem(16'hFF00, 16'h0000);
    set_exp(16'hFC00, 16'h0000, 16'h0000, 1'b0);
    run_frame("v2", 0, 18);

    // 4.0 under 5-cycle output backpressure per neuron
    set_x(16'h0100); set_mem(16'h0100, 16'h0000);
    set_exp(16'h0400, 16'h0400, 16'h0100, 1'b0);
    run_frame("v3", 1, 28);

    set_x(16'h0100); set_mem(16'h0000, 16'h0000);
    set_exp(16'h0000, 16'h0000, 16'h0080, 1'b0);
    run_frame("v4", 0, 18);

    set_x(16'h0100); set_mem(16'h0000, 16'h0400);
    set_exp(16'h0400, 16'h0400, 16'h0100, 1'b0);
    run_frame("v5", 0, 18);

    set_x(16'h0100); set_mem(16'h0000, 16'hFC00);
    set_exp(16'hFC00, 16'h0000, 16'h0000, 1'b0);
    run_frame("v6", 0, 18);

    set_x(16'h7FFF); set_mem(16'h7FFF, 16'h0000);
    set_exp(16'h7FFF, 16'h7FFF, 16'h0100, 1'b1);
    run_frame("v7", 0, 18);

    set_x(16'h7FFF); set_mem(16'h8000, 16'h0000);
    set_exp(16'h8000, 16'h0000, 16'h0000, 1'b1);
    run_frame("v8", 0, 18);

    // Reset two cycles into neuron 1 accumulation
    set_x(16'h0100); set_mem(16'h0100, 16'h0080);
    set_exp(16'h0480, 16'h0480, 16'h0100, 1'b0);
    feed("rm", t0);
    take("rm", 0, 0, t1);
    @(negedge clk);
    chk_eq("rm_mid_mem_en", 32'(mem_en[0]), 32'd1);
    chk_eq("rm_mid_mem_addr", 32'(mem_addr[0]), 32'd6);
    chk_eq("rm_mid_busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rm_rst", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_reset("rm_rel", 1'b1);

    // Distinct inputs and per-neuron weights: n0 = 10.0, n1 = 1 - 4 + 0.5 = -2.5
    xv[0] = 16'h0100; xv[1] = 16'h0200; xv[2] = 16'h0300; xv[3] = 16'h0400;
    mem[0] = 16'h0100; mem[1] = 16'h0100; mem[2] = 16'h0100; mem[3] = 16'h0100;
    mem[4] = 16'h0000;
    mem[5] = 16'h0100; mem[6] = 16'h0000; mem[7] = 16'h0000; mem[8] = 16'hFF00;
    mem[9] = 16'h0080;
    ev[0][0] = 16'h0A00; ev[1][0] = 16'h0A00; ev[2][0] = 16'h0100; es[0] = 1'b0;
    ev[0][1] = 16'hFD80; ev[1][1] = 16'h0000; ev[2][1] = 16'h0000; es[1] = 1'b0;
    run_frame("v9", 0, 18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
